// File: rtl/line_fill_responder.sv
// line_fill_responder: queues line fill requests from the L1 data cache and
// assembles each line from single-beat downstream reads, one beat in flight.
module line_fill_responder #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int BEAT_W     = 32,
    parameter int REQ_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_req_valid,
    input  logic [ADDR_W-1:0]       mem_req_addr,
    output logic                    mem_resp_valid,
    output logic [LINE_BYTES*8-1:0] mem_resp_data,
    output logic                    beat_req_valid,
    output logic [ADDR_W-1:0]       beat_req_addr,
    input  logic                    beat_req_ready,
    input  logic                    beat_rsp_valid,
    input  logic [BEAT_W-1:0]       beat_rsp_data,
    output logic                    busy,
    output logic                    overflow_err
);

    // BEATS must be a power of two of at least 2 for beat_idx to cover the line exactly
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int BEAT_BYTES = BEAT_W / 8;
    localparam int IDX_W      = $clog2(BEATS);
    localparam int PTR_W      = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int CNT_W      = $clog2(REQ_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fifo_q [REQ_DEPTH];
    logic [ADDR_W-1:0]  fifo_d [REQ_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [IDX_W-1:0]   beat_idx_q, beat_idx_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [LINE_W-1:0]  resp_data_q, resp_data_d;
    logic               push;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(REQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Fill sequencer: fetch each beat, wait for its data, then present the line
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        beat_idx_d  = beat_idx_q;
        line_d      = line_q;
        resp_data_d = resp_data_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    base_d     = fifo_q[rd_ptr_q];
                    beat_idx_d = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (beat_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (beat_rsp_valid) begin
                    line_d[beat_idx_q*BEAT_W +: BEAT_W] = beat_rsp_data;
                    if (beat_idx_q == IDX_W'(BEATS - 1)) begin
                        resp_data_d = line_d;
                        state_d     = RESP;
                    end else begin
                        beat_idx_d = beat_idx_q + 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            RESP: begin
                pop     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request queue: a full queue still accepts a push when the head leaves in the same cycle
    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push       = mem_req_valid && ((count_q != CNT_W'(REQ_DEPTH)) || pop);
        overflow_d = overflow_q | (mem_req_valid & ~push);
        if (push) begin
            fifo_d[wr_ptr_q] = mem_req_addr & LINE_MASK;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State and datapath registers; reset discards any fill in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fifo_q      <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            base_q      <= '0;
            beat_idx_q  <= '0;
            line_q      <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            base_q      <= base_d;
            beat_idx_q  <= beat_idx_d;
            line_q      <= line_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign mem_resp_valid = (state_q == RESP);
    assign mem_resp_data  = resp_data_q;
    assign beat_req_valid = (state_q == FETCH);
    assign beat_req_addr  = (state_q == FETCH)
                          ? base_q + ADDR_W'(beat_idx_q) * ADDR_W'(BEAT_BYTES)
                          : '0;
    assign busy           = (state_q != IDLE) || (count_q != '0);
    assign overflow_err   = overflow_q;

endmodule

// File: tb/tb_line_fill_responder.sv
// Testbench for line_fill_responder: table of single fills plus hand-written
// queueing, overflow and reset sequences, checked against a response scoreboard.
module tb_line_fill_responder;

    localparam int ADDR_W     = 32;
    localparam int LINE_BYTES = 64;
    localparam int BEAT_W     = 32;
    localparam int REQ_DEPTH  = 4;
    localparam int BEATS      = 16;
    localparam int LINE_W     = 512;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [LINE_W-1:0] mem_resp_data;
    logic              beat_req_valid;
    logic [ADDR_W-1:0] beat_req_addr;
    logic              beat_req_ready;
    logic              beat_rsp_valid;
    logic [BEAT_W-1:0] beat_rsp_data;
    logic              busy;
    logic              overflow_err;

    line_fill_responder #(
        .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .BEAT_W(BEAT_W), .REQ_DEPTH(REQ_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .beat_req_valid(beat_req_valid), .beat_req_addr(beat_req_addr),
        .beat_req_ready(beat_req_ready), .beat_rsp_valid(beat_rsp_valid),
        .beat_rsp_data(beat_rsp_data), .busy(busy), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] line;
        logic [31:0] seed;
        int          reqCycle;
        int          expLat;
    } sbEntry_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] seed;
        int          stall;
        int          expLat;
    } vec_t;

    sbEntry_t    sb[$];
    vec_t        vecs[4];
    int          checks = 0;
    int          failures = 0;
    int          cycleCnt = 0;
    int          stallCycles = 0;
    int          lowCnt = 0;
    int          beatCnt = 0;
    bit          pending = 0;
    logic [31:0] pendAddr;
    logic [31:0] pendSeed;
    logic [31:0] heldAddr;

    // Downstream memory contents: each line is its seed xor line address, plus beat number
    function automatic logic [31:0] beatData(input logic [31:0] seed, input logic [31:0] addr);
        return (seed ^ (addr & 32'hFFFF_FFC0)) + {28'd0, addr[5:2]};
    endfunction

    function automatic logic [LINE_W-1:0] expLine(input logic [31:0] seed, input logic [31:0] line);
        logic [LINE_W-1:0] r;
        r = '0;
        for (int k = 0; k < BEATS; k++) begin
            r[k*32 +: 32] = (seed ^ line) + 32'(k);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                               input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: event did not occur as required", name);
    endtask

    // One clock: emulate downstream memory, check beat addresses and pop responses
    task automatic tick();
        sbEntry_t e;
        @(negedge clk);
        cycleCnt++;
        if (!rst_n) begin
            pending        = 0;
            beatCnt        = 0;
            lowCnt         = 0;
            beat_rsp_valid = 1'b0;
            beat_rsp_data  = '0;
            beat_req_ready = 1'b1;
            return;
        end
        beat_rsp_valid = 1'b0;
        beat_rsp_data  = '0;
        if (pending) begin
            beat_rsp_valid = 1'b1;
            beat_rsp_data  = beatData(pendSeed, pendAddr);
            pending        = 0;
        end
        if (beat_req_valid) begin
            if (lowCnt > 0) begin
                checkOutput("beat_addr_stable", 512'(beat_req_addr), 512'(heldAddr));
            end
            heldAddr = beat_req_addr;
            if (lowCnt < stallCycles) begin
                beat_req_ready = 1'b0;
                lowCnt++;
                if (!beat_rsp_valid) begin
                    beat_rsp_valid = 1'b1;
                    beat_rsp_data  = 32'hDEAD_BEEF;
                end
            end else begin
                beat_req_ready = 1'b1;
                if (sb.size() == 0) begin
                    failNow("beat_without_request");
                    pendSeed = '0;
                end else begin
                    checkOutput("beat_addr", 512'(beat_req_addr), 512'(sb[0].line + 32'(beatCnt * 4)));
                    pendSeed = sb[0].seed;
                end
                pending  = 1;
                pendAddr = beat_req_addr;
                beatCnt  = (beatCnt + 1) % BEATS;
                lowCnt   = 0;
            end
        end else begin
            beat_req_ready = (stallCycles == 0);
        end
        if (mem_resp_valid) begin
            if (sb.size() == 0) begin
                failNow("unexpected_resp");
            end else begin
                e = sb.pop_front();
                checkOutput("resp_data", mem_resp_data, expLine(e.seed, e.line));
                if (e.expLat >= 0) begin
                    checkOutput("resp_latency", 512'(cycleCnt - e.reqCycle), 512'(e.expLat));
                end
            end
        end
    endtask

    // Drive one request for one cycle; accepted requests are expected back on the scoreboard
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] seed,
                                 input int lat, input bit accept);
        sbEntry_t e;
        mem_req_valid = 1'b1;
        mem_req_addr  = addr;
        if (accept) begin
            e.line     = addr & 32'hFFFF_FFC0;
            e.seed     = seed;
            e.reqCycle = cycleCnt;
            e.expLat   = lat;
            sb.push_back(e);
        end
        tick();
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_pending", 512'(sb.size()), 512'd0);
        checkOutput("drain_busy", 512'(busy), 512'd0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_resp_valid"}, 512'(mem_resp_valid), 512'd0);
        checkOutput({tag, "_resp_data"}, mem_resp_data, 512'd0);
        checkOutput({tag, "_beat_valid"}, 512'(beat_req_valid), 512'd0);
        checkOutput({tag, "_beat_addr"}, 512'(beat_req_addr), 512'd0);
        checkOutput({tag, "_busy"}, 512'(busy), 512'd0);
        checkOutput({tag, "_overflow"}, 512'(overflow_err), 512'd0);
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        checkReset(tag);
        sb.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [LINE_W-1:0] single;
        int n;

        vecs[0] = '{addr: 32'h0000_1234, seed: 32'hA000_1200, stall: 0, expLat: 34};
        vecs[1] = '{addr: 32'h8000_0048, seed: 32'h5555_0000, stall: 3, expLat: 82};
        vecs[2] = '{addr: 32'hFFFF_FFC5, seed: 32'h0123_4567, stall: 0, expLat: 34};
        vecs[3] = '{addr: 32'h0000_0000, seed: 32'h0F0F_0F0F, stall: 1, expLat: 50};

        rst_n          = 1'b1;
        mem_req_valid  = 1'b0;
        mem_req_addr   = '0;
        beat_req_ready = 1'b1;
        beat_rsp_valid = 1'b0;
        beat_rsp_data  = '0;
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("por");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] single fills from table");
        for (int i = 0; i < 4; i++) begin
            stallCycles = vecs[i].stall;
            applyStimulus(vecs[i].addr, vecs[i].seed, vecs[i].expLat, 1'b1);
            checkOutput("busy_during_fill", 512'(busy), 512'd1);
            waitDrain(300);
            checkOutput("no_overflow", 512'(overflow_err), 512'd0);
            if (i == 0) begin
                for (int k = 0; k < BEATS; k++) begin
                    single[k*32 +: 32] = 32'hA000_0000 + 32'(k);
                end
                checkOutput("single_fill_held_data", mem_resp_data, single);
            end
        end

        $display("[TB] four queued requests");
        stallCycles = 0;
        applyStimulus(32'h0000_0100, 32'h1111_0001, 34, 1'b1);
        applyStimulus(32'h0000_0200, 32'h2222_0002, 67, 1'b1);
        applyStimulus(32'h0000_0300, 32'h3333_0003, 100, 1'b1);
        applyStimulus(32'h0000_0400, 32'h4444_0004, 133, 1'b1);
        waitDrain(400);
        checkOutput("queue_no_overflow", 512'(overflow_err), 512'd0);

        $display("[TB] overflow on fifth request");
        applyStimulus(32'h0000_1000, 32'h5150_0001, 34, 1'b1);
        applyStimulus(32'h0000_2000, 32'h5250_0002, 67, 1'b1);
        applyStimulus(32'h0000_3000, 32'h5350_0003, 100, 1'b1);
        applyStimulus(32'h0000_4000, 32'h5450_0004, 133, 1'b1);
        applyStimulus(32'h0000_5000, 32'h5550_0005, -1, 1'b0);
        checkOutput("overflow_set", 512'(overflow_err), 512'd1);
        waitDrain(400);
        checkOutput("overflow_sticky", 512'(overflow_err), 512'd1);
        doReset("rst_after_overflow");

        $display("[TB] push while full during response cycle");
        applyStimulus(32'h0000_0A00, 32'h6100_0001, 34, 1'b1);
        applyStimulus(32'h0000_0B00, 32'h6200_0002, 67, 1'b1);
        applyStimulus(32'h0000_0C00, 32'h6300_0003, 100, 1'b1);
        applyStimulus(32'h0000_0D00, 32'h6400_0004, 133, 1'b1);
        n = 0;
        while (!mem_resp_valid && n < 100) begin
            tick();
            n++;
        end
        if (!mem_resp_valid) begin
            failNow("first_resp_timeout");
        end
        applyStimulus(32'h0000_0E00, 32'h6500_0005, 136, 1'b1);
        checkOutput("full_pop_no_overflow", 512'(overflow_err), 512'd0);
        waitDrain(400);
        checkOutput("full_pop_no_overflow_end", 512'(overflow_err), 512'd0);

        $display("[TB] reset during beat 7");
        applyStimulus(32'h0000_7700, 32'h7700_0077, 34, 1'b1);
        n = 0;
        while (!(beatCnt == 7 && beat_req_valid) && n < 100) begin
            tick();
            n++;
        end
        if (!(beatCnt == 7 && beat_req_valid)) begin
            failNow("beat7_timeout");
        end
        rst_n = 1'b0;
        #1;
        checkReset("mid_fill");
        sb.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        checkOutput("post_reset_idle", 512'(busy), 512'd0);
        applyStimulus(32'h0000_8840, 32'h8800_0088, 34, 1'b1);
        waitDrain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_fill_responder.md
LINE_FILL_RESPONDER -- requirements
Module: line_fill_responder

Interface
REQ-001 Parameters, one per line, SHALL be:
- ADDR_W, 32, address width
- LINE_BYTES, 64, cache line size in bytes
- BEAT_W, 32, downstream data beat width in bits
- REQ_DEPTH, 4, request queue entries (matches cache MSHR count)

REQ-002 Ports, one per line (name, direction, width, meaning), SHALL be:
- clk, in, 1, single clock
- rst_n, in, 1, asynchronous active-low reset
- mem_req_valid, in, 1, line fill request pulse from the L1 data cache
- mem_req_addr, in, ADDR_W, request address
- mem_resp_valid, out, 1, one-cycle pulse: line returned
- mem_resp_data, out, LINE_BYTES*8, returned line, beat 0 in the LSBs
- beat_req_valid, out, 1, downstream beat read request
- beat_req_addr, out, ADDR_W, downstream beat byte address
- beat_req_ready, in, 1, downstream accepts the beat request
- beat_rsp_valid, in, 1, downstream beat data valid
- beat_rsp_data, in, BEAT_W, downstream beat data
- busy, out, 1, FSM not IDLE or queue not empty
- overflow_err, out, 1, sticky: a request was dropped

REQ-003 Derived values SHALL be BEATS = LINE_BYTES*8/BEAT_W and BEAT_BYTES = BEAT_W/8; BEATS SHALL be a power of two ≥2.

Function
REQ-004 The request input SHALL have no ready signal; every cycle with mem_req_valid=1 SHALL be a new request.
REQ-005 Each accepted request SHALL be pushed into an in-order FIFO of REQ_DEPTH entries, with its address line-aligned (low log2(LINE_BYTES) bits forced to 0).
REQ-006 A push SHALL be accepted when count<REQ_DEPTH, or when count==REQ_DEPTH and a pop occurs in the same cycle.
REQ-007 Otherwise the request SHALL be dropped, overflow_err SHALL be set, and overflow_err SHALL stay set until reset.
REQ-008 The FIFO pointers SHALL wrap modulo REQ_DEPTH, and count SHALL be unchanged on a simultaneous push and pop.
REQ-009 The FSM SHALL have the states IDLE, FETCH, WAIT and RESP.
REQ-010 In IDLE, if the FIFO is non-empty, the FSM SHALL latch the head address as base, clear beat_idx, and move to FETCH.
REQ-011 In FETCH, beat_req_valid SHALL be 1 and beat_req_addr SHALL be base + beat_idx*BEAT_BYTES.
REQ-012 In FETCH, beat_req_valid and beat_req_addr SHALL stay stable until beat_req_ready=1, after which the FSM SHALL move to WAIT.
REQ-013 At most one beat SHALL be outstanding at any time.
REQ-014 In WAIT, on beat_rsp_valid=1 the FSM SHALL write beat_rsp_data into line slot beat_idx (bits beat_idx*BEAT_W upward).
REQ-015 On that response, if beat_idx==BEATS-1 the FSM SHALL move to RESP; otherwise it SHALL increment beat_idx and return to FETCH.
REQ-016 beat_rsp_valid outside WAIT SHALL be ignored.
REQ-017 In RESP, mem_resp_valid SHALL be 1 for exactly one cycle, the FIFO head SHALL be popped, and the FSM SHALL return to IDLE.
REQ-018 mem_resp_data SHALL be registered, SHALL update only when RESP is entered, and SHALL hold between responses.
REQ-019 Responses SHALL return in request order.
REQ-020 With beat_req_ready tied to 1 and each beat responding the cycle after its handshake, an isolated request in cycle 0 SHALL produce mem_resp_valid in cycle 2+2*BEATS (34 with the defaults).
REQ-021 A request arriving during an active fill SHALL be queued and SHALL NOT disturb that fill.
REQ-022 busy SHALL be 1 whenever state≠IDLE or count≠0.

Reset
REQ-023 Reset assertion SHALL take effect immediately, at any point including mid-fill.
REQ-024 On reset, state=IDLE, FIFO empty, beat_idx=0, mem_resp_valid=0, mem_resp_data=0, beat_req_valid=0, beat_req_addr=0, busy=0 and overflow_err=0.
REQ-025 A fill interrupted by reset SHALL be discarded and SHALL produce no response.

Verification
REQ-026 Single fill: req addr 0x0000_1234 in cycle 0, ready=1, beat k data = 0xA000_0000+k -> beat addrs 0x1200..0x123C in steps of 4; mem_resp_valid in cycle 34 only; data word k = 0xA000_0000+k.
REQ-027 Back-pressure: beat_req_ready low 3 cycles in each FETCH -> beat_req_addr stable while ready is low; response delayed by 48 cycles; data correct.
REQ-028 Queueing: 4 requests to 0x100, 0x200, 0x300, 0x400 in consecutive cycles -> 4 responses in that order, no overflow_err.
REQ-029 Overflow: 5 requests in consecutive cycles with no pop -> the 5th is dropped; overflow_err=1 and stays set; exactly 4 responses.
REQ-030 Full with simultaneous pop: FIFO full and a push in the RESP cycle -> push accepted, count stays 4, overflow_err=0.
REQ-031 Reset mid-fill: rst_n low during beat 7 -> all outputs reset immediately; no mem_resp_valid; next request completes normally.
